// File: rtl/compress_pkg.sv
// Shared constants and state encoding for the run-length bit compressor.
package compress_pkg;

    localparam int RUN_W   = 3;                  // run-length code width
    localparam int MAX_RUN = (1 << RUN_W) - 1;   // longest run a single code carries
    localparam int BYTE_W  = 8;                  // input symbol width

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCAN,
        SAT,
        FLUSH,
        FIN
    } state_t;

endpackage

// File: rtl/compress_outreg.sv
// Single-entry valid/ready holding register for the code stream.
module compress_outreg #(
    parameter int RUN_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [RUN_W-1:0] push_code,
    input  logic             code_ready,
    output logic [RUN_W-1:0] code_out,
    output logic             code_valid,
    output logic             can_push
);
    import compress_pkg::*;

    logic             valid_q, valid_d;
    logic [RUN_W-1:0] code_q, code_d;

    // A new code fits when the slot is empty or is being drained this cycle.
    assign can_push   = !valid_q || code_ready;
    assign code_out   = code_q;
    assign code_valid = valid_q;

    // Drain on accept, refill on push; code stays frozen while stalled.
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        if (valid_q && code_ready) valid_d = 1'b0;
        if (push && can_push) begin
            valid_d = 1'b1;
            code_d  = push_code;
        end
    end

    // Register state with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            code_q  <= '0;
        end else begin
            valid_q <= valid_d;
            code_q  <= code_d;
        end
    end

endmodule

// File: rtl/compress.sv
// Run-length encoder: bytes are scanned MSB-first into alternating runs of
// 0s and 1s (first run is 0s), each run emitted as a RUN_W-bit count.
// Runs longer than the code can hold are split as MAX, 0, remainder.
module compress #(
    parameter int RUN_W = compress_pkg::RUN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             work,
    input  logic [7:0]       in_byte,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [RUN_W-1:0] code_out,
    output logic             code_valid,
    input  logic             code_ready,
    output logic [31:0]      byteIndx,
    output logic [3:0]       bitIndx,
    output logic             done
);
    import compress_pkg::*;

    localparam logic [RUN_W-1:0] RUN_MAX  = '1;
    localparam logic [RUN_W-1:0] RUN_PRE  = RUN_MAX - 1'b1;
    localparam logic [3:0]       LAST_BIT = 4'(BYTE_W - 1);
    localparam logic [3:0]       END_BIT  = 4'(BYTE_W);

    state_t             state_q, state_d;
    logic [BYTE_W-1:0]  byte_q, byte_d;
    logic               last_q, last_d;
    logic [RUN_W-1:0]   cnt_q, cnt_d;
    logic               run_q, run_d;
    logic [3:0]         bit_q, bit_d;
    logic [31:0]        idx_q, idx_d;
    logic               emitted_q, emitted_d;
    logic               done_q, done_d;

    logic               push, can_push, advance;
    logic [RUN_W-1:0]   push_code;
    state_t             end_state;

    compress_outreg #(.RUN_W(RUN_W)) u_outreg (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_code  (push_code),
        .code_ready (code_ready),
        .code_out   (code_out),
        .code_valid (code_valid),
        .can_push   (can_push)
    );

    assign in_ready = (state_q == LOAD);
    assign byteIndx = idx_q;
    assign bitIndx  = bit_q;
    assign done     = done_q;

    // Next-state, bit scanning and code emission; emitting states wait for a free slot.
    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        bit_d     = bit_q;
        idx_d     = idx_q;
        emitted_d = emitted_q;
        done_d    = 1'b0;
        push      = 1'b0;
        push_code = '0;
        advance   = 1'b0;
        end_state = last_q ? FLUSH : LOAD;
        case (state_q)
            IDLE: if (work) begin
                state_d   = LOAD;
                cnt_d     = '0;
                run_d     = 1'b0;
                bit_d     = '0;
                idx_d     = '0;
                emitted_d = 1'b0;
            end
            LOAD: if (in_valid) begin
                byte_d  = in_byte;
                last_d  = in_last;
                idx_d   = idx_q + 32'd1;
                bit_d   = '0;
                state_d = SCAN;
            end
            SCAN: begin
                if (byte_q[BYTE_W-1] != run_q) begin
                    // Run ends: emit it and start the opposite run with this bit.
                    if (can_push) begin
                        push      = 1'b1;
                        push_code = cnt_q;
                        run_d     = !run_q;
                        cnt_d     = {{(RUN_W-1){1'b0}}, 1'b1};
                        advance   = 1'b1;
                    end
                end else if (cnt_q == RUN_PRE) begin
                    // Run hits the code limit: emit MAX now, the 0 spacer in SAT.
                    if (can_push) begin
                        push      = 1'b1;
                        push_code = RUN_MAX;
                        cnt_d     = '0;
                        advance   = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    advance = 1'b1;
                end
                if (advance) begin
                    byte_d = {byte_q[BYTE_W-2:0], 1'b0};
                    bit_d  = bit_q + 4'd1;
                    if (cnt_q == RUN_PRE && byte_q[BYTE_W-1] == run_q) state_d = SAT;
                    else if (bit_q == LAST_BIT)                        state_d = end_state;
                end
            end
            SAT: if (can_push) begin
                push      = 1'b1;
                push_code = '0;
                state_d   = (bit_q == END_BIT) ? end_state : SCAN;
            end
            FLUSH: begin
                // An all-empty stream still produces one code.
                if (cnt_q != '0 || !emitted_q) begin
                    if (can_push) begin
                        push      = 1'b1;
                        push_code = cnt_q;
                        state_d   = FIN;
                    end
                end else begin
                    state_d = FIN;
                end
            end
            FIN: if (!code_valid) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (push) emitted_d = 1'b1;
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            byte_q    <= '0;
            last_q    <= 1'b0;
            cnt_q     <= '0;
            run_q     <= 1'b0;
            bit_q     <= '0;
            idx_q     <= '0;
            emitted_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            bit_q     <= bit_d;
            idx_q     <= idx_d;
            emitted_q <= emitted_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_compress.sv
// Bench for compress: table of byte streams with expected code sequences,
// scoreboard queue of codes, plus a mid-stream reset sequence.
module tb_compress;

    localparam int RUN_W = compress_pkg::RUN_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             work;
    logic [7:0]       in_byte;
    logic             in_last;
    logic             in_valid;
    logic             in_ready;
    logic [RUN_W-1:0] code_out;
    logic             code_valid;
    logic             code_ready;
    logic [31:0]      byteIndx;
    logic [3:0]       bitIndx;
    logic             done;

    compress #(.RUN_W(RUN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .work       (work),
        .in_byte    (in_byte),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .byteIndx   (byteIndx),
        .bitIndx    (bitIndx),
        .done       (done)
    );

    always #5 clk = ~clk;

    // bytes: first byte in [23:16]; codes: one octal digit per code, first leftmost
    typedef struct {
        logic [23:0] bytes;
        int          nb;
        logic [29:0] codes;
        int          nc;
        int          stall;
        bit          poke;
    } vec_t;

    vec_t       vecs[8];
    logic [2:0] exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int bi = 0, wait_n = 0, last_acc = -1, done_at = -1, done_n = 0;
        int xfer_at = -1, first_v = -1, stall_err = 0;
        logic [2:0] held = '0, e;
        bit holding = 0;
        for (int i = 0; i < v.nc; i++) exp_q.push_back(v.codes[29-3*i -: 3]);
        work = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 600; cyc++) begin
            work       = v.poke && (cyc == 4);
            in_valid   = (bi < v.nb);
            in_byte    = (bi < v.nb) ? v.bytes[23-8*bi -: 8] : 8'h00;
            in_last    = (bi == v.nb - 1);
            code_ready = (wait_n >= v.stall);
            if (in_valid && in_ready) begin
                if (xfer_at < 0) xfer_at = cyc;
                bi++;
            end
            if (code_valid) begin
                if (first_v < 0) first_v = cyc;
                if (holding && code_out != held) stall_err++;
                if (code_ready) begin
                    if (exp_q.size() == 0) chk($sformatf("v%0d extra code", id), code_out, 8);
                    else begin
                        e = exp_q.pop_front();
                        chk($sformatf("v%0d code", id), code_out, e);
                    end
                    wait_n   = 0;
                    holding  = 0;
                    last_acc = cyc;
                end else begin
                    wait_n++;
                    holding = 1;
                    held    = code_out;
                end
            end
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = cyc;
            end
            @(negedge clk);
            if (done_at >= 0 && cyc >= done_at + 3) break;
        end
        work = 1'b0; in_valid = 1'b0; in_last = 1'b0; code_ready = 1'b1;
        chk($sformatf("v%0d done seen", id), done_at >= 0, 1);
        chk($sformatf("v%0d done timing", id), done_at, last_acc + 2);
        chk($sformatf("v%0d done width", id), done_n, 1);
        chk($sformatf("v%0d codes left", id), exp_q.size(), 0);
        exp_q.delete();
        chk($sformatf("v%0d byteIndx", id), byteIndx, v.nb);
        chk($sformatf("v%0d bitIndx", id), bitIndx, 8);
        chk($sformatf("v%0d latency", id), first_v >= xfer_at + 2 && xfer_at >= 0, 1);
        if (v.stall > 0) chk($sformatf("v%0d stall stable", id), stall_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int dn;
        vecs[0] = '{24'h0F0000, 1, 30'o4400000000, 2, 0, 1'b0};
        vecs[1] = '{24'hFF0000, 1, 30'o0701000000, 4, 0, 1'b0};
        vecs[2] = '{24'h000000, 2, 30'o7070200000, 5, 0, 1'b0};
        vecs[3] = '{24'h7F0000, 1, 30'o1700000000, 3, 5, 1'b0};
        vecs[4] = '{24'hAA0000, 1, 30'o0111111110, 9, 0, 1'b1};
        vecs[5] = '{24'h0FF080, 3, 30'o4701417000, 8, 0, 1'b0};
        vecs[6] = '{24'h000000, 1, 30'o7010000000, 3, 2, 1'b0};
        vecs[7] = '{24'hF00000, 1, 30'o0440000000, 3, 0, 1'b0};

        rst = 1'b1; work = 1'b0; in_byte = '0; in_last = 1'b0; in_valid = 1'b0; code_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst code_valid", code_valid, 0);
        chk("rst code_out", code_out, 0);
        chk("rst in_ready", in_ready, 0);
        chk("rst done", done, 0);
        chk("rst byteIndx", byteIndx, 0);
        chk("rst bitIndx", bitIndx, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Mid-SCAN reset: pending state must vanish at once, no done afterwards.
        work = 1'b1;
        @(negedge clk);
        work = 1'b0; in_valid = 1'b1; in_byte = 8'h00; in_last = 1'b0;
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("mid bitIndx", bitIndx, 2);
        chk("mid byteIndx", byteIndx, 1);
        rst = 1'b1;
        #1;
        chk("mid rst code_valid", code_valid, 0);
        chk("mid rst code_out", code_out, 0);
        chk("mid rst in_ready", in_ready, 0);
        chk("mid rst byteIndx", byteIndx, 0);
        chk("mid rst bitIndx", bitIndx, 0);
        chk("mid rst done", done, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || in_ready || code_valid) dn++;
        end
        chk("post rst idle", dn, 0);

        run_vec(7, vecs[7]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
